// File: rtl/mem_bist_pkg.sv
// Shared types and constants for the memory BIST controller: FSM states and
// the 16-bit pattern LFSR definition.
package mem_bist_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR_REQ,
        ST_RD_REQ,
        ST_RD_WAIT,
        ST_DONE
    } bist_state_e;

    localparam logic [15:0] LFSR_SEED = 16'h0001;
    // Feedback taps at bits 15, 14, 12 and 3
    localparam logic [15:0] LFSR_TAPS = 16'hD008;

    function automatic logic [15:0] lfsr_next(input logic [15:0] cur);
        return {cur[14:0], ^(cur & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/lfsr16_step.sv
// 16-bit pattern LFSR. LOAD restores the seed and wins over EN; the next value
// is exported so the controller can register write data in the same cycle.
module lfsr16_step
    import mem_bist_pkg::*;
(
    input  logic        CLK,
    input  logic        RSTN,
    input  logic        EN,
    input  logic        LOAD,
    output logic [15:0] lfsr_q,
    output logic [15:0] lfsr_d
);

    logic [15:0] state_q;

    always_comb begin
        lfsr_d = state_q;
        if (LOAD) begin
            lfsr_d = LFSR_SEED;
        end else if (EN) begin
            lfsr_d = lfsr_next(state_q);
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q <= LFSR_SEED;
        end else begin
            state_q <= lfsr_d;
        end
    end

    assign lfsr_q = state_q;

endmodule

// File: rtl/mem_bist_ctrl.sv
// Memory BIST controller: writes an LFSR pattern to addresses 0..LAST_ADDR,
// reads it back one outstanding read at a time and counts mismatches.
module mem_bist_ctrl
    import mem_bist_pkg::*;
#(
    parameter int ADDR_W = 8,
    parameter int ERR_W  = 8
) (
    input  logic              CLK,
    input  logic              RSTN,
    input  logic              START,
    input  logic [ADDR_W-1:0] LAST_ADDR,
    output logic              MEM_REQ,
    output logic              MEM_WE,
    output logic [ADDR_W-1:0] MEM_ADDR,
    output logic [15:0]       MEM_WDATA,
    input  logic              MEM_GNT,
    input  logic              MEM_RVALID,
    input  logic [15:0]       MEM_RDATA,
    output logic              BUSY,
    output logic              DONE,
    output logic              PASS,
    output logic [ERR_W-1:0]  ERR_CNT,
    output logic [ADDR_W-1:0] ERR_ADDR
);

    bist_state_e       state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] last_q, last_d;
    logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0] err_addr_q, err_addr_d;
    logic              req_q, req_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] maddr_q, maddr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic              pass_q, pass_d;
    logic              lfsr_en, lfsr_load;
    logic [15:0]       lfsr_q, lfsr_d;

    lfsr16_step u_lfsr (
        .CLK    (CLK),
        .RSTN   (RSTN),
        .EN     (lfsr_en),
        .LOAD   (lfsr_load),
        .lfsr_q (lfsr_q),
        .lfsr_d (lfsr_d)
    );

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        last_d     = last_q;
        err_cnt_d  = err_cnt_q;
        err_addr_d = err_addr_q;
        lfsr_en    = 1'b0;
        lfsr_load  = 1'b0;
        unique case (state_q)
            ST_IDLE, ST_DONE: begin
                if (START) begin
                    last_d     = LAST_ADDR;
                    addr_d     = '0;
                    lfsr_load  = 1'b1;
                    err_cnt_d  = '0;
                    err_addr_d = '0;
                    state_d    = ST_WR_REQ;
                end
            end
            ST_WR_REQ: begin
                if (MEM_GNT) begin
                    lfsr_en = 1'b1;
                    // Read pass replays the pattern from the seed
                    if (addr_q == last_q) begin
                        lfsr_load = 1'b1;
                        addr_d    = '0;
                        state_d   = ST_RD_REQ;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end
            ST_RD_REQ: begin
                if (MEM_GNT) begin
                    state_d = ST_RD_WAIT;
                end
            end
            ST_RD_WAIT: begin
                if (MEM_RVALID) begin
                    lfsr_en = 1'b1;
                    if (MEM_RDATA != lfsr_q) begin
                        if (err_cnt_q == '0) begin
                            err_addr_d = addr_q;
                        end
                        if (err_cnt_q != '1) begin
                            err_cnt_d = err_cnt_q + 1'b1;
                        end
                    end
                    if (addr_q == last_q) begin
                        state_d = ST_DONE;
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = ST_RD_REQ;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with it
    always_comb begin
        req_d   = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ);
        we_d    = (state_d == ST_WR_REQ);
        maddr_d = addr_d;
        wdata_d = (state_d == ST_WR_REQ) ? lfsr_d : wdata_q;
        busy_d  = (state_d == ST_WR_REQ) || (state_d == ST_RD_REQ) || (state_d == ST_RD_WAIT);
        done_d  = (state_d == ST_DONE);
        pass_d  = (state_d == ST_DONE) && (err_cnt_d == '0);
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            last_q     <= '0;
            err_cnt_q  <= '0;
            err_addr_q <= '0;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            maddr_q    <= '0;
            wdata_q    <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            pass_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            last_q     <= last_d;
            err_cnt_q  <= err_cnt_d;
            err_addr_q <= err_addr_d;
            req_q      <= req_d;
            we_q       <= we_d;
            maddr_q    <= maddr_d;
            wdata_q    <= wdata_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            pass_q     <= pass_d;
        end
    end

    assign MEM_REQ   = req_q;
    assign MEM_WE    = we_q;
    assign MEM_ADDR  = maddr_q;
    assign MEM_WDATA = wdata_q;
    assign BUSY      = busy_q;
    assign DONE      = done_q;
    assign PASS      = pass_q;
    assign ERR_CNT   = err_cnt_q;
    assign ERR_ADDR  = err_addr_q;

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Randomized bench for mem_bist_ctrl: a transaction-level model predicts the
// request stream and status outputs, checked on every falling edge.
module tb_mem_bist_ctrl;

    localparam int AW      = 8;
    localparam int EW      = 2;
    localparam int ERR_MAX = 3;

    logic          CLK, RSTN, START;
    logic [AW-1:0] LAST_ADDR, MEM_ADDR, ERR_ADDR;
    logic          MEM_REQ, MEM_WE, MEM_GNT, MEM_RVALID;
    logic [15:0]   MEM_WDATA, MEM_RDATA;
    logic          BUSY, DONE, PASS;
    logic [EW-1:0] ERR_CNT;

    mem_bist_ctrl #(.ADDR_W(AW), .ERR_W(EW)) u_dut (
        .CLK        (CLK),
        .RSTN       (RSTN),
        .START      (START),
        .LAST_ADDR  (LAST_ADDR),
        .MEM_REQ    (MEM_REQ),
        .MEM_WE     (MEM_WE),
        .MEM_ADDR   (MEM_ADDR),
        .MEM_WDATA  (MEM_WDATA),
        .MEM_GNT    (MEM_GNT),
        .MEM_RVALID (MEM_RVALID),
        .MEM_RDATA  (MEM_RDATA),
        .BUSY       (BUSY),
        .DONE       (DONE),
        .PASS       (PASS),
        .ERR_CNT    (ERR_CNT),
        .ERR_ADDR   (ERR_ADDR)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    typedef struct {
        bit          we;
        int          addr;
        logic [15:0] data;
    } xact_t;

    xact_t       exp_q[$];
    xact_t       wr_log[$];
    logic [15:0] mem [0:255];
    bit          bad [0:255];
    logic [15:0] lit [5];

    int vectors = 0;
    int miscompares = 0;

    bit          m_active, m_fin, m_rd_out;
    int          m_errs, m_first, m_last, m_rd_addr, rd_delay;
    logic [15:0] m_rd_pat;

    bit          start_req;
    logic [AW-1:0] last_drv;
    int          gnt_mode, gnt_block;

    bit          p_start, p_gnt, p_rvalid, p_req;
    logic [15:0] p_rdata, p_wdata;
    int          p_addr, p_last;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] lfsr_adv(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[14] ^ v[12] ^ v[3]};
    endfunction

    task automatic begin_test(input int l);
        logic [15:0] p;
        xact_t x;
        m_active = 1; m_fin = 0; m_errs = 0; m_first = 0; m_last = l; m_rd_out = 0;
        exp_q.delete();
        wr_log.delete();
        for (int pass_i = 0; pass_i < 2; pass_i++) begin
            p = 16'h0001;
            for (int i = 0; i <= l; i++) begin
                x.we = (pass_i == 0); x.addr = i; x.data = p;
                exp_q.push_back(x);
                p = lfsr_adv(p);
            end
        end
    endtask

    task automatic update_model();
        bit was_active;
        xact_t x;
        was_active = m_active;
        if (was_active && m_rd_out && p_rvalid) begin
            if (p_rdata !== m_rd_pat) begin
                if (m_errs == 0) m_first = m_rd_addr;
                m_errs++;
            end
            m_rd_out = 0;
            if (m_rd_addr == m_last) begin
                m_active = 0;
                m_fin = 1;
            end
        end else if (was_active && !m_rd_out && p_req && p_gnt && exp_q.size() > 0) begin
            x = exp_q.pop_front();
            if (x.we) begin
                mem[p_addr[7:0]] = p_wdata;
                x.addr = p_addr; x.data = p_wdata;
                wr_log.push_back(x);
            end else begin
                m_rd_out = 1; m_rd_addr = x.addr; m_rd_pat = x.data;
                rd_delay = $urandom_range(0, 2);
            end
        end
        if (!was_active && p_start) begin_test(p_last);
    endtask

    task automatic compare_outputs();
        bit exp_req;
        int sat;
        exp_req = m_active && !m_rd_out;
        sat = (m_errs > ERR_MAX) ? ERR_MAX : m_errs;
        chk("mem_req", 32'(MEM_REQ), 32'(exp_req));
        if (exp_req && exp_q.size() > 0) begin
            chk("mem_we", 32'(MEM_WE), 32'(exp_q[0].we));
            chk("mem_addr", 32'(MEM_ADDR), exp_q[0].addr);
            if (exp_q[0].we) chk("mem_wdata", 32'(MEM_WDATA), 32'(exp_q[0].data));
        end
        chk("busy", 32'(BUSY), 32'(m_active));
        chk("done", 32'(DONE), 32'(m_fin));
        chk("pass", 32'(PASS), 32'(m_fin && m_errs == 0));
        chk("err_cnt", 32'(ERR_CNT), sat);
        chk("err_addr", 32'(ERR_ADDR), m_first);
    endtask

    task automatic drive_inputs();
        p_req = MEM_REQ; p_addr = int'(MEM_ADDR); p_wdata = MEM_WDATA;
        START = start_req;
        LAST_ADDR = last_drv;
        if (gnt_block > 0 && MEM_REQ) begin
            MEM_GNT = 1'b0;
            gnt_block--;
        end else if (gnt_mode == 0) begin
            MEM_GNT = 1'b1;
        end else begin
            MEM_GNT = ($urandom_range(0, 9) < 6);
        end
        if (m_rd_out) begin
            if (rd_delay == 0) begin
                MEM_RVALID = 1'b1;
                MEM_RDATA = bad[m_rd_addr] ? 16'h0000 : mem[m_rd_addr];
            end else begin
                rd_delay--;
                MEM_RVALID = 1'b0;
                MEM_RDATA = 16'($urandom);
            end
        end else begin
            // Stray RVALIDs outside a read wait must be ignored
            MEM_RVALID = ($urandom_range(0, 5) == 0);
            MEM_RDATA = 16'($urandom);
        end
        p_start = START; p_last = int'(LAST_ADDR);
        p_gnt = MEM_GNT; p_rvalid = MEM_RVALID; p_rdata = MEM_RDATA;
    endtask

    task automatic cycle();
        @(negedge CLK);
        if (!RSTN) begin
            m_active = 0; m_fin = 0; m_errs = 0; m_first = 0; m_rd_out = 0;
            exp_q.delete();
            chk("rst_req", 32'(MEM_REQ), 0);
            chk("rst_we", 32'(MEM_WE), 0);
            chk("rst_addr", 32'(MEM_ADDR), 0);
            chk("rst_wdata", 32'(MEM_WDATA), 0);
            chk("rst_busy", 32'(BUSY), 0);
            chk("rst_done", 32'(DONE), 0);
            chk("rst_pass", 32'(PASS), 0);
            chk("rst_err_cnt", 32'(ERR_CNT), 0);
            chk("rst_err_addr", 32'(ERR_ADDR), 0);
        end else begin
            update_model();
            compare_outputs();
        end
        drive_inputs();
    endtask

    task automatic start_test(input int l, input int extra);
        last_drv = l[AW-1:0];
        start_req = 1;
        cycle();
        for (int k = 0; k < extra; k++) begin
            last_drv = 8'($urandom);
            cycle();
        end
        start_req = 0;
    endtask

    task automatic wait_done(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!m_fin && n < budget);
        chk("test_done", 32'(DONE), 1);
    endtask

    initial begin
        RSTN = 1'b0; START = 1'b0; LAST_ADDR = '0;
        MEM_GNT = 1'b0; MEM_RVALID = 1'b0; MEM_RDATA = '0;
        start_req = 0; last_drv = '0; gnt_mode = 0; gnt_block = 0; rd_delay = 0;
        m_active = 0; m_fin = 0; m_rd_out = 0; m_errs = 0; m_first = 0; m_last = 0; m_rd_addr = 0;
        for (int i = 0; i < 256; i++) begin
            mem[i] = '0;
            bad[i] = 0;
        end
        lit = '{16'h0001, 16'h0002, 16'h0004, 16'h0008, 16'h0011};
        repeat (3) cycle();
        RSTN = 1'b1;
        cycle();

        // Always-granted pass over 0..4 with a clean memory
        gnt_mode = 0;
        start_test(4, 0);
        wait_done(200);
        chk("lit_wr_count", wr_log.size(), 5);
        for (int i = 0; i < 5; i++) begin
            if (i < wr_log.size()) begin
                chk("lit_wr_addr", wr_log[i].addr, i);
                chk("lit_wr_data", 32'(wr_log[i].data), 32'(lit[i]));
            end
        end
        chk("lit_pass", 32'(PASS), 1);
        chk("lit_err_cnt0", 32'(ERR_CNT), 0);

        // Address 2 reads back as zero
        bad[2] = 1;
        gnt_mode = 1;
        start_test(4, 1);
        wait_done(400);
        chk("lit_err_cnt1", 32'(ERR_CNT), 1);
        chk("lit_err_addr2", 32'(ERR_ADDR), 2);
        chk("lit_pass0", 32'(PASS), 0);
        bad[2] = 0;

        // First write withheld for three cycles
        gnt_block = 3;
        start_test(3, 0);
        wait_done(400);
        chk("lit_held_wr_count", wr_log.size(), 4);
        if (wr_log.size() > 0) chk("lit_held_wr_data", 32'(wr_log[0].data), 32'h0001);

        // Every read wrong: counter saturates, first address kept
        for (int i = 0; i < 8; i++) bad[i] = 1;
        start_test(7, 2);
        wait_done(600);
        chk("lit_err_sat", 32'(ERR_CNT), 3);
        chk("lit_err_addr0", 32'(ERR_ADDR), 0);
        for (int i = 0; i < 8; i++) bad[i] = 0;

        // Single address, then the full address space
        start_test(0, 2);
        wait_done(100);
        chk("lit_single_wr", wr_log.size(), 1);
        start_test(255, 1);
        wait_done(5000);
        chk("lit_full_wr", wr_log.size(), 256);
        chk("lit_full_pass", 32'(PASS), 1);

        // Randomized runs
        repeat (10) begin
            for (int i = 0; i < 256; i++) bad[i] = ($urandom_range(0, 7) == 0);
            gnt_mode = $urandom_range(0, 1);
            start_test($urandom_range(0, 40), $urandom_range(0, 2));
            wait_done(2000);
        end
        for (int i = 0; i < 256; i++) bad[i] = 0;

        // Reset while waiting on read data aborts the test
        gnt_mode = 1;
        start_test(20, 0);
        begin
            int n;
            n = 0;
            while (!(m_rd_out && m_rd_addr >= 3) && n < 500) begin
                cycle();
                n++;
            end
        end
        chk("rd_wait_reached", {30'd0, BUSY, MEM_REQ}, 32'h2);
        RSTN = 1'b0;
        cycle();
        cycle();
        RSTN = 1'b1;
        repeat (5) cycle();
        gnt_mode = 0;
        start_test(2, 0);
        wait_done(200);
        if (wr_log.size() > 0) begin
            chk("lit_rst_wr_addr", wr_log[0].addr, 0);
            chk("lit_rst_wr_data", 32'(wr_log[0].data), 32'h0001);
        end
        chk("lit_rst_pass", 32'(PASS), 1);

        repeat (3) cycle();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
